// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder.
// Decodes make and break sequences into held key state and one-cycle press and release
// pulses for ENTER, SPACE, '1' and '2'. It handles the E0, F0 and E1 prefixes.
// Ports:
//   CLOCK_50          system clock, all logic on posedge
//   reset             synchronous, active-high
//   received_data     scan code byte, valid while received_data_en=1
//   received_data_en  one-cycle strobe per received byte
//   key_down          held state {two,one,space,enter}
//   key_press         one-cycle pulse on not-held->held
//   key_release       one-cycle pulse on held->not-held
//   last_code         base code of last completed make/break
//   last_extended     last completed sequence carried E0
//   last_break        last completed sequence carried F0
//   seq_error         one-cycle pulse on inter-byte timeout abort
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter bit          KP_ENTER_EN    = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [3:0] key_down,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [7:0] last_code,
  output logic       last_extended,
  output logic       last_break,
  output logic       seq_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    skip_cnt, skip_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [3:0]    down_nxt, press_nxt, rel_nxt;
  logic [7:0]    code_nxt;
  logic          ext_nxt, brk_nxt, err_nxt;
  logic          do_update, upd_ext, upd_brk;
  logic          is_ctrl, is_prefix, map_hit;
  logic [1:0]    map_idx;

  // Bytes that never form part of a key code
  always_comb begin
    unique case (received_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default:                                                is_ctrl = 1'b0;
    endcase
    is_prefix = (received_data == 8'hE0) || (received_data == 8'hF0) ||
                (received_data == 8'hE1);
  end

  // Base code to key bit; only keypad Enter is mapped among extended codes
  always_comb begin
    map_hit = 1'b0;
    map_idx = 2'd0;
    if (!upd_ext) begin
      unique case (received_data)
        8'h5A: begin map_hit = 1'b1; map_idx = 2'd0; end
        8'h29: begin map_hit = 1'b1; map_idx = 2'd1; end
        8'h16: begin map_hit = 1'b1; map_idx = 2'd2; end
        8'h1E: begin map_hit = 1'b1; map_idx = 2'd3; end
        default: ;
      endcase
    end else if (KP_ENTER_EN && (received_data == 8'h5A)) begin
      map_hit = 1'b1;
      map_idx = 2'd0;
    end
  end

  // Next-state, timeout and output computation
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    tmo_nxt   = tmo_cnt;
    down_nxt  = key_down;
    press_nxt = 4'b0000;
    rel_nxt   = 4'b0000;
    code_nxt  = last_code;
    ext_nxt   = last_extended;
    brk_nxt   = last_break;
    err_nxt   = 1'b0;
    do_update = 1'b0;
    upd_ext   = 1'b0;
    upd_brk   = 1'b0;

    if (received_data_en) begin
      tmo_nxt = '0;
      unique case (state)
        S_IDLE: begin
          if (received_data == 8'hE0)      state_nxt = S_EXT;
          else if (received_data == 8'hF0) state_nxt = S_BRK;
          else if (received_data == 8'hE1) begin
            state_nxt = S_SKIP;
            skip_nxt  = PAUSE_SKIP;
          end else if (!is_ctrl)           do_update = 1'b1;
        end
        S_EXT: begin
          state_nxt = S_IDLE;
          upd_ext   = 1'b1;
          if (received_data == 8'hF0)             state_nxt = S_EXT_BRK;
          else if (!is_prefix && !is_ctrl)        do_update = 1'b1;
        end
        S_BRK, S_EXT_BRK: begin
          state_nxt = S_IDLE;
          upd_ext   = (state == S_EXT_BRK);
          upd_brk   = 1'b1;
          do_update = !is_prefix && !is_ctrl;
        end
        S_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        state_nxt = S_IDLE;
        err_nxt   = 1'b1;
        tmo_nxt   = '0;
      end else begin
        tmo_nxt = tmo_cnt + TW'(1);
      end
    end else begin
      tmo_nxt = '0;
    end

    if (do_update) begin
      code_nxt = received_data;
      ext_nxt  = upd_ext;
      brk_nxt  = upd_brk;
      if (map_hit) begin
        if (!upd_brk && !key_down[map_idx]) begin
          down_nxt[map_idx]  = 1'b1;
          press_nxt[map_idx] = 1'b1;
        end else if (upd_brk && key_down[map_idx]) begin
          down_nxt[map_idx] = 1'b0;
          rel_nxt[map_idx]  = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= S_IDLE;
      skip_cnt      <= 3'd0;
      tmo_cnt       <= '0;
      key_down      <= 4'b0000;
      key_press     <= 4'b0000;
      key_release   <= 4'b0000;
      last_code     <= 8'h00;
      last_extended <= 1'b0;
      last_break    <= 1'b0;
      seq_error     <= 1'b0;
    end else begin
      state         <= state_nxt;
      skip_cnt      <= skip_nxt;
      tmo_cnt       <= tmo_nxt;
      key_down      <= down_nxt;
      key_press     <= press_nxt;
      key_release   <= rel_nxt;
      last_code     <= code_nxt;
      last_extended <= ext_nxt;
      last_break    <= brk_nxt;
      seq_error     <= err_nxt;
    end
  end

endmodule
